// File: rtl/char_palette_fsm.sv
// Stateful per-character palette decoder: per-ghost NORMAL/FRIGHT/EATEN tracking,
// frame-based fright timer with end-of-fright flashing, one-stage registered output.
module char_palette_fsm #(
   parameter int N_GHOST       = 4,
   parameter int CHAR_W        = 4,
   parameter int FRIGHT_FRAMES = 360,
   parameter int FLASH_FRAMES  = 120,
   parameter int FLASH_HALF    = 7,
   parameter int TMR_W         = 9
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic [CHAR_W-1:0]  i_which_char,
   input  logic [1:0]         i_data_ghost,
   input  logic               i_data_pacman,
   input  logic               i_frame_tick,
   input  logic               i_fright_start,
   input  logic [N_GHOST-1:0] i_ghost_eaten,
   input  logic [N_GHOST-1:0] i_ghost_home,
   output logic               o_valid,
   output logic [3:0]         o_data_ghost_process,
   output logic [3:0]         o_data_pacman_process,
   output logic               o_fright_active,
   output logic               o_flashing
);

   localparam logic [3:0] COLOR_BLACK  = 4'd0;
   localparam logic [3:0] COLOR_BLUE   = 4'd1;
   localparam logic [3:0] COLOR_WHITE  = 4'd2;
   localparam logic [3:0] COLOR_RED    = 4'd3;
   localparam logic [3:0] COLOR_PINK   = 4'd4;
   localparam logic [3:0] COLOR_LBLUE  = 4'd5;
   localparam logic [3:0] COLOR_ORANGE = 4'd6;
   localparam logic [3:0] COLOR_YELLOW = 4'd7;

   localparam int DIV_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
   localparam logic [TMR_W-1:0] FRIGHT_C = TMR_W'(FRIGHT_FRAMES);
   localparam logic [TMR_W-1:0] FLASH_C  = TMR_W'(FLASH_FRAMES);
   localparam logic [TMR_W-1:0] ONE_C    = TMR_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_HALF - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   typedef enum logic [1:0] {
      MODE_NORMAL = 2'd0,
      MODE_FRIGHT = 2'd1,
      MODE_EATEN  = 2'd2
   } mode_e;

   mode_e            mode_q [N_GHOST];
   mode_e            mode_d [N_GHOST];
   logic [TMR_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             phase_q, phase_d;
   logic             valid_q;
   logic [3:0]       ghost_q, ghost_d;
   logic [3:0]       pacman_q, pacman_d;

   logic             flash_now, flash_next, expiry;
   mode_e            sel_mode;
   logic [3:0]       body_col;

   // Fright timer and flash divider
   always_comb begin
      flash_now = (cnt_q != '0) && (cnt_q <= FLASH_C);
      expiry    = i_frame_tick && (cnt_q == ONE_C) && !i_fright_start;
      cnt_d     = cnt_q;
      if (i_fright_start)
         cnt_d = FRIGHT_C;
      else if (i_frame_tick && (cnt_q != '0))
         cnt_d = cnt_q - ONE_C;
      flash_next = (cnt_d != '0) && (cnt_d <= FLASH_C);

      div_d   = div_q;
      phase_d = phase_q;
      // Divider only advances on ticks taken from inside the window, so entry starts at phase 0.
      if (i_fright_start || !flash_next) begin
         div_d   = '0;
         phase_d = 1'b0;
      end else if (i_frame_tick && flash_now) begin
         if (div_q == DIV_LAST) begin
            div_d   = '0;
            phase_d = ~phase_q;
         end else begin
            div_d = div_q + DIV_ONE;
         end
      end
   end

   always_comb begin
      for (int unsigned g = 0; g < N_GHOST; g++) begin
         mode_d[g] = mode_q[g];
         case (mode_q[g])
            MODE_NORMAL: if (i_fright_start) mode_d[g] = MODE_FRIGHT;
            MODE_FRIGHT: begin
               if (i_ghost_eaten[g])
                  mode_d[g] = MODE_EATEN;
               else if (expiry)
                  mode_d[g] = MODE_NORMAL;
            end
            MODE_EATEN:  if (i_ghost_home[g]) mode_d[g] = MODE_NORMAL;
            default:     mode_d[g] = MODE_NORMAL;
         endcase
      end
   end

   // Colour lookup uses the mode as it stood before this cycle's updates
   always_comb begin
      sel_mode = MODE_NORMAL;
      body_col = COLOR_WHITE;
      for (int unsigned g = 0; g < N_GHOST; g++) begin
         if (i_which_char == CHAR_W'(g + 1)) begin
            sel_mode = mode_q[g];
            case (g)
               0:       body_col = COLOR_RED;
               1:       body_col = COLOR_PINK;
               2:       body_col = COLOR_LBLUE;
               3:       body_col = COLOR_ORANGE;
               default: body_col = COLOR_WHITE;
            endcase
         end
      end

      ghost_d  = ghost_q;
      pacman_d = pacman_q;
      if (i_valid) begin
         pacman_d = i_data_pacman ? COLOR_YELLOW : COLOR_BLACK;
         case (sel_mode)
            MODE_FRIGHT: begin
               if (flash_now && phase_q) begin
                  case (i_data_ghost)
                     2'd0:    ghost_d = COLOR_BLACK;
                     2'd3:    ghost_d = COLOR_WHITE;
                     default: ghost_d = COLOR_RED;
                  endcase
               end else begin
                  case (i_data_ghost)
                     2'd0:    ghost_d = COLOR_BLACK;
                     2'd3:    ghost_d = COLOR_BLUE;
                     default: ghost_d = COLOR_WHITE;
                  endcase
               end
            end
            MODE_EATEN: begin
               case (i_data_ghost)
                  2'd1:    ghost_d = COLOR_BLUE;
                  2'd2:    ghost_d = COLOR_WHITE;
                  default: ghost_d = COLOR_BLACK;
               endcase
            end
            default: begin
               case (i_data_ghost)
                  2'd0:    ghost_d = COLOR_BLACK;
                  2'd1:    ghost_d = COLOR_BLUE;
                  2'd2:    ghost_d = COLOR_WHITE;
                  default: ghost_d = body_col;
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned g = 0; g < N_GHOST; g++)
            mode_q[g] <= MODE_NORMAL;
         cnt_q    <= '0;
         div_q    <= '0;
         phase_q  <= 1'b0;
         valid_q  <= 1'b0;
         ghost_q  <= COLOR_BLACK;
         pacman_q <= COLOR_BLACK;
      end else begin
         for (int unsigned g = 0; g < N_GHOST; g++)
            mode_q[g] <= mode_d[g];
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         phase_q  <= phase_d;
         valid_q  <= i_valid;
         ghost_q  <= ghost_d;
         pacman_q <= pacman_d;
      end
   end

   assign o_valid               = valid_q;
   assign o_data_ghost_process  = ghost_q;
   assign o_data_pacman_process = pacman_q;
   assign o_fright_active       = (cnt_q != '0);
   assign o_flashing            = flash_now;

endmodule

// File: tb/tb_char_palette_fsm.sv
// Self-checking bench for char_palette_fsm: NORMAL-map table, directed fright/eaten
// sequences and random traffic against an arithmetic reference model.
module tb_char_palette_fsm;

   localparam int N_GHOST = 4;
   localparam int CHAR_W  = 4;
   localparam int FRIGHT  = 360;
   localparam int FLASH   = 120;
   localparam int HALF    = 7;
   localparam int TMR_W   = 9;

   localparam logic [3:0] BLACK  = 4'd0;
   localparam logic [3:0] BLUE   = 4'd1;
   localparam logic [3:0] WHITE  = 4'd2;
   localparam logic [3:0] RED    = 4'd3;
   localparam logic [3:0] PINK   = 4'd4;
   localparam logic [3:0] LBLUE  = 4'd5;
   localparam logic [3:0] ORANGE = 4'd6;
   localparam logic [3:0] YELLOW = 4'd7;

   logic               clk = 1'b0;
   logic               rst;
   logic               valid;
   logic [CHAR_W-1:0]  which_char;
   logic [1:0]         data_ghost;
   logic               data_pacman;
   logic               frame_tick;
   logic               fright_start;
   logic [N_GHOST-1:0] ghost_eaten;
   logic [N_GHOST-1:0] ghost_home;
   logic               o_valid;
   logic [3:0]         o_ghost;
   logic [3:0]         o_pacman;
   logic               o_active;
   logic               o_flash;

   always #5 clk = ~clk;

   char_palette_fsm #(
      .N_GHOST(N_GHOST), .CHAR_W(CHAR_W), .FRIGHT_FRAMES(FRIGHT),
      .FLASH_FRAMES(FLASH), .FLASH_HALF(HALF), .TMR_W(TMR_W)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_which_char(which_char),
      .i_data_ghost(data_ghost), .i_data_pacman(data_pacman),
      .i_frame_tick(frame_tick), .i_fright_start(fright_start),
      .i_ghost_eaten(ghost_eaten), .i_ghost_home(ghost_home),
      .o_valid(o_valid), .o_data_ghost_process(o_ghost),
      .o_data_pacman_process(o_pacman), .o_fright_active(o_active),
      .o_flashing(o_flash)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: 0 = normal, 1 = fright, 2 = eaten
   int         m_cnt;
   int         m_mode [N_GHOST];
   logic       e_valid;
   logic [3:0] e_ghost, e_pac;

   function automatic logic [3:0] ref_colour(input int id, input int gd);
      int mode, ph;
      logic [3:0] body;
      mode = (id >= 1 && id <= N_GHOST) ? m_mode[id-1] : 0;
      ph   = (m_cnt > 0 && m_cnt <= FLASH) ? ((FLASH - m_cnt) / HALF) % 2 : 0;
      case (id)
         1: body = RED;  2: body = PINK;  3: body = LBLUE;  4: body = ORANGE;
         default: body = WHITE;
      endcase
      if (mode == 1) begin
         if (gd == 0) return BLACK;
         if (ph == 1) return (gd == 3) ? WHITE : RED;
         return (gd == 3) ? BLUE : WHITE;
      end
      if (mode == 2) return (gd == 1) ? BLUE : (gd == 2) ? WHITE : BLACK;
      return (gd == 0) ? BLACK : (gd == 1) ? BLUE : (gd == 2) ? WHITE : body;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic v, input int id, input int gd, input logic pac,
                       input logic tick, input logic start,
                       input logic [N_GHOST-1:0] eaten, input logic [N_GHOST-1:0] home,
                       input logic r);
      bit expiry;
      rst = r; valid = v; which_char = CHAR_W'(id); data_ghost = 2'(gd);
      data_pacman = pac; frame_tick = tick; fright_start = start;
      ghost_eaten = eaten; ghost_home = home;
      if (r) begin
         m_cnt = 0;
         for (int g = 0; g < N_GHOST; g++) m_mode[g] = 0;
         e_valid = 1'b0; e_ghost = BLACK; e_pac = BLACK;
      end else begin
         e_valid = v;
         if (v) begin
            e_ghost = ref_colour(id, gd);
            e_pac   = pac ? YELLOW : BLACK;
         end
         expiry = tick && m_cnt == 1 && !start;
         for (int g = 0; g < N_GHOST; g++) begin
            if (m_mode[g] == 0 && start) m_mode[g] = 1;
            else if (m_mode[g] == 1 && eaten[g]) m_mode[g] = 2;
            else if (m_mode[g] == 1 && expiry) m_mode[g] = 0;
            else if (m_mode[g] == 2 && home[g]) m_mode[g] = 0;
         end
         if (start) m_cnt = FRIGHT;
         else if (tick && m_cnt > 0) m_cnt = m_cnt - 1;
      end
      @(posedge clk);
      #1;
      check("valid", {3'b0, o_valid}, {3'b0, e_valid});
      check("ghost", o_ghost, e_ghost);
      check("pacman", o_pacman, e_pac);
      check("active", {3'b0, o_active}, {3'b0, (m_cnt != 0)});
      check("flashing", {3'b0, o_flash}, {3'b0, (m_cnt != 0 && m_cnt <= FLASH)});
   endtask

   task automatic pix(input int id, input int gd);
      step(1'b1, id, gd, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic ctl(input logic start, input logic [N_GHOST-1:0] eaten,
                      input logic [N_GHOST-1:0] home);
      step(1'b0, 0, 0, 1'b0, 1'b0, start, eaten, home, 1'b0);
   endtask

   typedef struct {
      int         id;
      int         gd;
      logic       pac;
      logic [3:0] exp_ghost;
      logic [3:0] exp_pac;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{1, 3, 1'b1, RED,    YELLOW};
      tbl[1] = '{2, 3, 1'b0, PINK,   BLACK};
      tbl[2] = '{3, 3, 1'b1, LBLUE,  YELLOW};
      tbl[3] = '{4, 3, 1'b0, ORANGE, BLACK};
      tbl[4] = '{0, 3, 1'b1, WHITE,  YELLOW};
      tbl[5] = '{5, 3, 1'b0, WHITE,  BLACK};
      tbl[6] = '{1, 0, 1'b1, BLACK,  YELLOW};
      tbl[7] = '{2, 1, 1'b0, BLUE,   BLACK};
      tbl[8] = '{3, 2, 1'b1, WHITE,  YELLOW};
      tbl[9] = '{15, 2, 1'b0, WHITE, BLACK};

      // Reset state
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      step(1'b1, 1, 3, 1'b1, 1'b1, 1'b1, '1, '1, 1'b1);
      check("rst_valid", {3'b0, o_valid}, 4'd0);
      check("rst_ghost", o_ghost, BLACK);
      check("rst_active", {3'b0, o_active}, 4'd0);

      // NORMAL colour map
      for (int i = 0; i < 10; i++) begin
         step(1'b1, tbl[i].id, tbl[i].gd, tbl[i].pac, 1'b0, 1'b0, '0, '0, 1'b0);
         check($sformatf("tbl%0d_ghost", i), o_ghost, tbl[i].exp_ghost);
         check($sformatf("tbl%0d_pac", i), o_pacman, tbl[i].exp_pac);
      end

      // Fright with flashing through to expiry
      ctl(1'b1, '0, '0);
      pix(2, 3);
      check("t2_blue", o_ghost, BLUE);
      check("t2_active", {3'b0, o_active}, 4'd1);
      ticks(FRIGHT - FLASH);
      pix(2, 3);
      check("t2_flash", {3'b0, o_flash}, 4'd1);
      check("t2_flash_blue", o_ghost, BLUE);
      ticks(HALF);
      pix(2, 3);
      check("t2_white_body", o_ghost, WHITE);
      pix(2, 1);
      check("t2_red_eye", o_ghost, RED);
      ticks(HALF);
      pix(2, 3);
      check("t2_blue_again", o_ghost, BLUE);
      ticks(FLASH - 2 * HALF);
      check("t2_expired", {3'b0, o_active}, 4'd0);
      pix(2, 3);
      check("t2_pink", o_ghost, PINK);

      // Eaten, second fright ignored, home
      ctl(1'b1, '0, '0);
      ctl(1'b0, 4'b0001, '0);
      pix(1, 3);
      check("t3_eaten_body", o_ghost, BLACK);
      pix(1, 2);
      check("t3_eaten_white", o_ghost, WHITE);
      ctl(1'b1, '0, '0);
      pix(1, 3);
      check("t3_still_eaten", o_ghost, BLACK);
      ctl(1'b0, '0, 4'b0001);
      pix(1, 3);
      check("t3_home_red", o_ghost, RED);

      // Expiry tick coinciding with fright_start and eaten[1]
      ticks(FRIGHT - 1);
      check("t4_cnt1", {3'b0, o_active}, 4'd1);
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 4'b0010, '0, 1'b0);
      pix(2, 3);
      check("t4_ghost1_eaten", o_ghost, BLACK);
      pix(1, 3);
      check("t4_ghost0_fright", o_ghost, BLUE);
      pix(3, 3);
      check("t4_ghost2_fright", o_ghost, BLUE);

      // Reset mid-flash with ghost 3 eaten
      ctl(1'b0, 4'b0100, '0);
      ticks(FRIGHT - FLASH + 9);
      check("t5_flashing", {3'b0, o_flash}, 4'd1);
      step(1'b1, 3, 3, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
      check("t5_rst_ghost", o_ghost, BLACK);
      check("t5_rst_pac", o_pacman, BLACK);
      check("t5_rst_flash", {3'b0, o_flash}, 4'd0);
      pix(4, 3);
      check("t5_orange", o_ghost, ORANGE);
      pix(3, 3);
      check("t5_lblue", o_ghost, LBLUE);

      // Valid gating and eaten with no fright
      pix(1, 3);
      step(1'b0, 2, 3, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      check("t6_valid_low", {3'b0, o_valid}, 4'd0);
      check("t6_held", o_ghost, RED);
      pix(2, 3);
      check("t6_pink", o_ghost, PINK);
      ctl(1'b0, '1, '0);
      pix(1, 3);
      check("t6_eaten_ignored", o_ghost, RED);

      // Random traffic against the reference model
      for (int n = 0; n < 6000; n++) begin
         logic [N_GHOST-1:0] eat, hom;
         for (int g = 0; g < N_GHOST; g++) begin
            eat[g] = ($urandom_range(0, 15) == 0);
            hom[g] = ($urandom_range(0, 15) == 0);
         end
         step(1'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
              1'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 599) == 0),
              eat, hom, ($urandom_range(0, 4999) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
